// File: rtl/alu_core.sv
// 16-op ALU with registered NZVC flags and a combinational result.
// Define ALU_REG_RESULT_EN to register the result as well (latency 1, reset to 0).
module alu_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              carr,
  input  logic [3:0]        controller,
  input  logic              c,
  output logic [3:0]        nzvc,
  output logic [DATA_W-1:0] RdData_OR_memAddr
);

  typedef enum logic [3:0] {
    OpAdd, OpAdc, OpSbc, OpSub, OpRsb, OpRsc, OpAnd, OpOrr,
    OpEor, OpBic, OpMov, OpMvn, OpCmp, OpCmn, OpTst, OpTeq
  } op_e;

  op_e               op;
  logic [DATA_W-1:0] add_x;
  logic [DATA_W-1:0] add_y;
  logic              add_cin;
  logic              is_arith;
  logic              is_cmp;
  logic [DATA_W-1:0] logic_res;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result_d;
  logic              ovf;
  logic [3:0]        nzvc_d;
  logic [3:0]        nzvc_q;

  assign op = op_e'(controller);

  // Every arithmetic op is folded onto one adder: x + y + cin, with y inverted for subtracts.
  always_comb begin
    add_x     = src1;
    add_y     = src2;
    add_cin   = 1'b0;
    is_arith  = 1'b0;
    logic_res = '0;
    unique case (op)
      OpAdd, OpCmn: begin
        is_arith = 1'b1;
      end
      OpAdc: begin
        add_cin  = carr;
        is_arith = 1'b1;
      end
      OpSbc: begin
        add_y    = ~src2;
        add_cin  = carr;
        is_arith = 1'b1;
      end
      OpSub, OpCmp: begin
        add_y    = ~src2;
        add_cin  = 1'b1;
        is_arith = 1'b1;
      end
      OpRsb: begin
        add_x    = src2;
        add_y    = ~src1;
        add_cin  = 1'b1;
        is_arith = 1'b1;
      end
      OpRsc: begin
        add_x    = src2;
        add_y    = ~src1;
        add_cin  = carr;
        is_arith = 1'b1;
      end
      OpAnd, OpTst: logic_res = src1 & src2;
      OpOrr:        logic_res = src1 | src2;
      OpEor, OpTeq: logic_res = src1 ^ src2;
      OpBic:        logic_res = src1 & ~src2;
      OpMov:        logic_res = src2;
      OpMvn:        logic_res = ~src2;
      default:      logic_res = '0;
    endcase
  end

  assign sum      = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};
  assign result_d = is_arith ? sum[DATA_W-1:0] : logic_res;
  assign ovf      = (add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                    (sum[DATA_W-1] != add_x[DATA_W-1]);
  assign is_cmp   = (op == OpCmp) || (op == OpCmn) || (op == OpTst) || (op == OpTeq);

  // Logical ops pass carry-in through as C and keep the registered V.
  always_comb begin
    nzvc_d    = '0;
    nzvc_d[3] = result_d[DATA_W-1];
    nzvc_d[2] = (result_d == '0);
    nzvc_d[1] = is_arith ? ovf : nzvc_q[1];
    nzvc_d[0] = is_arith ? sum[DATA_W] : carr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nzvc_q <= 4'b0000;
    end else if (c || is_cmp) begin
      nzvc_q <= nzvc_d;
    end
  end

  assign nzvc = nzvc_q;

`ifdef ALU_REG_RESULT_EN
  logic [DATA_W-1:0] result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign RdData_OR_memAddr = result_q;
`else
  assign RdData_OR_memAddr = result_d;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: each vector is driven, clocked once, then the
// result and the flags are compared against hand-computed values.
module tb_alu_core;

  logic        clk;
  logic        reset;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        carr;
  logic [3:0]  controller;
  logic        c;
  logic [3:0]  nzvc;
  logic [31:0] result;

  int unsigned n_checks;
  int unsigned n_fail;

  alu_core #(
    .DATA_W(32)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .src1             (src1),
    .src2             (src2),
    .carr             (carr),
    .controller       (controller),
    .c                (c),
    .nzvc             (nzvc),
    .RdData_OR_memAddr(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic run_vec(input string tag, input logic rst, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic cen, input logic [31:0] exp_res, input logic [3:0] exp_f);
    logic [31:0] want_res;
    want_res = exp_res;
`ifdef ALU_REG_RESULT_EN
    if (rst) want_res = '0;
`endif
    @(negedge clk);
    reset      = rst;
    controller = op;
    src1       = a;
    src2       = b;
    carr       = ci;
    c          = cen;
    @(posedge clk);
    #1;
    check_eq({tag, "_res"}, result, want_res);
    check_eq({tag, "_nzvc"}, {28'd0, nzvc}, {28'd0, exp_f});
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    src1       = '0;
    src2       = '0;
    carr       = 1'b0;
    controller = 4'd0;
    c          = 1'b0;

    //       tag        rst   op     src1          src2          carr  c     result        nzvc
    run_vec("rst",      1'b1, 4'd0,  32'd1,        32'd1,        1'b0, 1'b1, 32'd2,        4'b0000);
    run_vec("sbc",      1'b0, 4'd2,  32'd30,       32'd40,       1'b1, 1'b0, 32'hFFFFFFF6, 4'b0000);
    run_vec("add_wrap", 1'b0, 4'd0,  32'hFFFFFFFF, 32'd1,        1'b0, 1'b1, 32'h0,        4'b0101);
    run_vec("add_ovf",  1'b0, 4'd0,  32'h7FFFFFFF, 32'd1,        1'b0, 1'b1, 32'h80000000, 4'b1010);
    run_vec("and_vkep", 1'b0, 4'd6,  32'hF0,       32'h0F,       1'b1, 1'b1, 32'h0,        4'b0111);
    run_vec("cmp_eq",   1'b0, 4'd12, 32'd5,        32'd5,        1'b0, 1'b0, 32'h0,        4'b0101);
    run_vec("adc",      1'b0, 4'd1,  32'd1,        32'd2,        1'b1, 1'b1, 32'd4,        4'b0000);
    run_vec("sub_neg",  1'b0, 4'd3,  32'd3,        32'd5,        1'b0, 1'b1, 32'hFFFFFFFE, 4'b1000);
    run_vec("rsb",      1'b0, 4'd4,  32'd3,        32'd5,        1'b0, 1'b1, 32'd2,        4'b0001);
    run_vec("rsc",      1'b0, 4'd5,  32'd5,        32'd5,        1'b0, 1'b1, 32'hFFFFFFFF, 4'b1000);
    run_vec("orr",      1'b0, 4'd7,  32'h0F0,      32'h00F,      1'b0, 1'b1, 32'hFF,       4'b0000);
    run_vec("eor",      1'b0, 4'd8,  32'hFF00FF00, 32'hFFFF0000, 1'b1, 1'b1, 32'h00FFFF00, 4'b0001);
    run_vec("bic_hold", 1'b0, 4'd9,  32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b0, 32'hFFFF0000, 4'b0001);
    run_vec("mov",      1'b0, 4'd10, 32'h0,        32'h12345678, 1'b0, 1'b1, 32'h12345678, 4'b0000);
    run_vec("mvn",      1'b0, 4'd11, 32'h0,        32'h0,        1'b1, 1'b1, 32'hFFFFFFFF, 4'b1001);
    run_vec("cmn_ovf",  1'b0, 4'd13, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h0,        4'b0111);
    run_vec("tst",      1'b0, 4'd14, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000, 4'b1010);
    run_vec("teq",      1'b0, 4'd15, 32'd5,        32'd5,        1'b1, 1'b0, 32'h0,        4'b0111);
    run_vec("sbc_ovf",  1'b0, 4'd2,  32'h80000000, 32'd1,        1'b1, 1'b1, 32'h7FFFFFFF, 4'b0011);
    run_vec("add_hold", 1'b0, 4'd0,  32'd1,        32'd1,        1'b0, 1'b0, 32'd2,        4'b0011);
    run_vec("rst_mid",  1'b1, 4'd12, 32'd5,        32'd5,        1'b0, 1'b1, 32'h0,        4'b0000);
    run_vec("post_rst", 1'b0, 4'd0,  32'd0,        32'd0,        1'b0, 1'b1, 32'h0,        4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
